// File: rtl/sensors_pkg.sv
// Shared types and width rules for the sequential sensor scan/statistics block.
package sensors_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam int DEF_NR_OF_SENSORS = 5;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_SUM_WIDTH     = 16;
    localparam int DEF_CNT_WIDTH     = 8;

    // Sum must hold N full-scale samples; count must hold the value N.
    function automatic bit widths_ok(input int n, input int dw, input int sw, input int cw);
        return (n >= 1) && (sw >= dw + $clog2(n + 1)) && (cw >= $clog2(n + 1));
    endfunction

endpackage

// File: rtl/sensor_stat_accum.sv
// Running sum/count/min/max/alarm accumulator. The o_*_nxt outputs show the
// state including the current sample, independent of a simultaneous clear.
module sensor_stat_accum
    import sensors_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_upd,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic [DATA_WIDTH-1:0] i_threshold,
    output logic [SUM_WIDTH-1:0]  o_sum_nxt,
    output logic [CNT_WIDTH-1:0]  o_cnt_nxt,
    output logic [DATA_WIDTH-1:0] o_min_nxt,
    output logic [DATA_WIDTH-1:0] o_max_nxt,
    output logic                  o_alarm_nxt
);

    logic [SUM_WIDTH-1:0]  r_sum;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_min;
    logic [DATA_WIDTH-1:0] r_max;
    logic                  r_alarm;

    always_comb begin
        o_sum_nxt   = r_sum;
        o_cnt_nxt   = r_cnt;
        o_min_nxt   = r_min;
        o_max_nxt   = r_max;
        o_alarm_nxt = r_alarm;
        if (i_upd) begin
            o_sum_nxt   = r_sum + SUM_WIDTH'(i_sample);
            o_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
            o_min_nxt   = (i_sample < r_min) ? i_sample : r_min;
            o_max_nxt   = (i_sample > r_max) ? i_sample : r_max;
            o_alarm_nxt = r_alarm | (i_sample > i_threshold);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum   <= '0;
            r_cnt   <= '0;
            r_min   <= '1;
            r_max   <= '0;
            r_alarm <= 1'b0;
        end else if (i_clr) begin
            r_sum   <= '0;
            r_cnt   <= '0;
            r_min   <= '1;
            r_max   <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_sum   <= o_sum_nxt;
            r_cnt   <= o_cnt_nxt;
            r_min   <= o_min_nxt;
            r_max   <= o_max_nxt;
            r_alarm <= o_alarm_nxt;
        end
    end

endmodule

// File: rtl/sensors_scan_stats.sv
// Snapshots all sensors on start, scans one per clock, and publishes
// sum/count/min/max/alarm with a one-cycle done pulse.
//   state   | meaning
//   ST_IDLE | waiting for start_i, results hold last scan
//   ST_SCAN | one snapshot sensor accumulated per clock
module sensors_scan_stats
    import sensors_pkg::*;
#(
    parameter int NR_OF_SENSORS = DEF_NR_OF_SENSORS,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SUM_WIDTH     = DEF_SUM_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [NR_OF_SENSORS*DATA_WIDTH-1:0] sensors_data_i,
    input  logic [NR_OF_SENSORS-1:0]            sensors_en_i,
    input  logic [DATA_WIDTH-1:0]               threshold_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [SUM_WIDTH-1:0]                temp_sum_o,
    output logic [CNT_WIDTH-1:0]                nr_active_sensors_o,
    output logic [DATA_WIDTH-1:0]               temp_min_o,
    output logic [DATA_WIDTH-1:0]               temp_max_o,
    output logic                                none_active_o,
    output logic                                alarm_o
);

    localparam int IDX_W = (NR_OF_SENSORS > 1) ? $clog2(NR_OF_SENSORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_OF_SENSORS - 1);

    if (!widths_ok(NR_OF_SENSORS, DATA_WIDTH, SUM_WIDTH, CNT_WIDTH)) begin : g_width_check
        $error("sensors_scan_stats: SUM_WIDTH/CNT_WIDTH too small for NR_OF_SENSORS/DATA_WIDTH");
    end

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    logic [IDX_W-1:0]                    r_idx;
    logic [NR_OF_SENSORS*DATA_WIDTH-1:0] r_data;
    logic [NR_OF_SENSORS-1:0]            r_en;
    logic [DATA_WIDTH-1:0]               r_thr;
    logic [DATA_WIDTH-1:0]               w_samples [NR_OF_SENSORS];
    logic [DATA_WIDTH-1:0]               w_sample;
    logic                                w_last;
    logic                                w_start;
    logic                                w_upd;

    logic [SUM_WIDTH-1:0]  w_sum_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_min_nxt;
    logic [DATA_WIDTH-1:0] w_max_nxt;
    logic                  w_alarm_nxt;

    // A start on the final scan edge re-arms immediately, giving one result every N cycles.
    assign w_last  = (r_state == ST_SCAN) && (r_idx == LAST_IDX);
    assign w_start = start_i && ((r_state == ST_IDLE) || w_last);
    assign w_upd   = (r_state == ST_SCAN) && r_en[r_idx];

    for (genvar k = 0; k < NR_OF_SENSORS; k++) begin : g_unpack
        assign w_samples[k] = r_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    assign w_sample = w_samples[r_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_last && !start_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == ST_SCAN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx  <= '0;
            r_data <= '0;
            r_en   <= '0;
            r_thr  <= '0;
        end else if (w_start) begin
            r_idx  <= '0;
            r_data <= sensors_data_i;
            r_en   <= sensors_en_i;
            r_thr  <= threshold_i;
        end else if (r_state == ST_SCAN) begin
            r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    sensor_stat_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_accum (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_clr       (w_start),
        .i_upd       (w_upd),
        .i_sample    (w_sample),
        .i_threshold (r_thr),
        .o_sum_nxt   (w_sum_nxt),
        .o_cnt_nxt   (w_cnt_nxt),
        .o_min_nxt   (w_min_nxt),
        .o_max_nxt   (w_max_nxt),
        .o_alarm_nxt (w_alarm_nxt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_o              <= 1'b0;
            temp_sum_o          <= '0;
            nr_active_sensors_o <= '0;
            temp_min_o          <= '0;
            temp_max_o          <= '0;
            none_active_o       <= 1'b0;
            alarm_o             <= 1'b0;
        end else begin
            done_o <= w_last;
            if (w_last) begin
                temp_sum_o          <= w_sum_nxt;
                nr_active_sensors_o <= w_cnt_nxt;
                temp_min_o          <= (w_cnt_nxt == '0) ? '0 : w_min_nxt;
                temp_max_o          <= w_max_nxt;
                none_active_o       <= (w_cnt_nxt == '0);
                alarm_o             <= w_alarm_nxt;
            end
        end
    end

endmodule
